rr_arbiter_4: RTL and testbench

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

---
 rtl/rr_arbiter_4.sv | 107 ++++++++++
 tb/tb_rr_arbiter_4.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered grant index and one-bubble handover.
// Optional grant-hold timeout enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  output logic       o_valid,
  output logic [1:0] o_grant_idx,
  output logic       o_timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q;
  logic [1:0] last_idx_q;
  logic [1:0] pick;
  logic       holder_req;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_4: MAX_HOLD must be in 2..255");
  end

  assign holder_req = i_req[o_grant_idx];

  // Search starts one past the last grant, so the previous holder is considered last.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = last_idx_q + 2'd1;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_idx_q + 2'(k);
      if (!found && i_req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_q;
  logic       expire;

  assign expire = (hold_cnt_q == HoldLast);
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      o_valid     <= 1'b0;
      o_grant_idx <= 2'b00;
      last_idx_q  <= 2'b11;
`ifdef ARB_TIMEOUT_EN
      o_timeout   <= 1'b0;
      hold_cnt_q  <= 8'd0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          o_valid <= 1'b0;
          if (|i_req) begin
            o_grant_idx <= pick;
            o_valid     <= 1'b1;
            state_q     <= StGrant;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= 8'd0;
`endif
          end
        end
        StGrant: begin
`ifdef ARB_TIMEOUT_EN
          if (holder_req && !expire) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end else begin
            // A still-requesting holder here means forced release.
            o_timeout  <= holder_req;
            o_valid    <= 1'b0;
            last_idx_q <= o_grant_idx;
            state_q    <= StIdle;
          end
`else
          if (!holder_req) begin
            o_valid    <= 1'b0;
            last_idx_q <= o_grant_idx;
            state_q    <= StIdle;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed scoreboard bench for rr_arbiter_4; covers the timeout path when ARB_TIMEOUT_EN is set.
module tb_rr_arbiter_4;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TbMaxHold = 4;
`else
  localparam int unsigned TbMaxHold = 16;
`endif

  logic       i_clk;
  logic       i_rst_n;
  logic [3:0] i_req;
  logic       o_valid;
  logic [1:0] o_grant_idx;
  logic       o_timeout;

  typedef struct {
    logic       v;
    logic [1:0] idx;
    logic       t;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  rr_arbiter_4 #(.MAX_HOLD(TbMaxHold)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .o_valid    (o_valid),
    .o_grant_idx(o_grant_idx),
    .o_timeout  (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check();
    exp_t e;
    e = sb.pop_front();
    tests++;
    assert (o_valid === e.v) else begin
      failed++;
      $error("FAIL %s valid: got %b want %b", e.tag, o_valid, e.v);
    end
    tests++;
    assert (o_grant_idx === e.idx) else begin
      failed++;
      $error("FAIL %s grant_idx: got %0d want %0d", e.tag, o_grant_idx, e.idx);
    end
    tests++;
    assert (o_timeout === e.t) else begin
      failed++;
      $error("FAIL %s timeout: got %b want %b", e.tag, o_timeout, e.t);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge, then check.
  task automatic step(input logic [3:0] req, input logic rst_n, input logic v,
                      input logic [1:0] idx, input logic t, input string tag);
    exp_t e;
    i_req   = req;
    i_rst_n = rst_n;
    e.v     = v;
    e.idx   = idx;
    e.t     = t;
    e.tag   = tag;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    check();
  endtask

  initial begin
    i_req   = 4'b0000;
    i_rst_n = 1'b0;
    #1;
    step(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, "reset0");
    step(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, "reset1");

    // Single requester 2: one-cycle latency, drop, idx held in idle.
    step(4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, "r025_grant");
    step(4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, "r025_hold1");
    step(4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, "r025_hold2");
    step(4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, "r025_release");
    step(4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, "r025_idle_idx");

    // Full request rotation from reset: 0,1,2,3,0 with one bubble each.
    step(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, "r024_reset");
    step(4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, "r024_g0");
    step(4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, "r024_h0");
    step(4'b1110, 1'b1, 1'b0, 2'd0, 1'b0, "r024_b0");
    step(4'b1110, 1'b1, 1'b1, 2'd1, 1'b0, "r024_g1");
    step(4'b1110, 1'b1, 1'b1, 2'd1, 1'b0, "r024_h1");
    step(4'b1101, 1'b1, 1'b0, 2'd1, 1'b0, "r024_b1");
    step(4'b1101, 1'b1, 1'b1, 2'd2, 1'b0, "r024_g2");
    step(4'b1101, 1'b1, 1'b1, 2'd2, 1'b0, "r024_h2");
    step(4'b1011, 1'b1, 1'b0, 2'd2, 1'b0, "r024_b2");
    step(4'b1011, 1'b1, 1'b1, 2'd3, 1'b0, "r024_g3");
    step(4'b1011, 1'b1, 1'b1, 2'd3, 1'b0, "r024_h3");
    step(4'b0111, 1'b1, 1'b0, 2'd3, 1'b0, "r024_b3");
    step(4'b0111, 1'b1, 1'b1, 2'd0, 1'b0, "r024_g0_wrap");
    step(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, "r024_done");

    // Pointer at 3, requests 0 and 3: wrap to 0 first, then 3.
    step(4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, "r026_set3");
    step(4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, "r026_rel3");
    step(4'b1001, 1'b1, 1'b1, 2'd0, 1'b0, "r026_wrap0");
    step(4'b1001, 1'b1, 1'b1, 2'd0, 1'b0, "r026_hold0");
    step(4'b1000, 1'b1, 1'b0, 2'd0, 1'b0, "r026_bubble");
    step(4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, "r026_g3");

    // Holder drops while others rise: release first, arbitrate next cycle.
    step(4'b0110, 1'b1, 1'b0, 2'd3, 1'b0, "r017_release");
    step(4'b0110, 1'b1, 1'b1, 2'd1, 1'b0, "r017_arb");
    step(4'b1111, 1'b1, 1'b1, 2'd1, 1'b0, "r013_hold");
    step(4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, "r016_drop");
    step(4'b0010, 1'b1, 1'b1, 2'd1, 1'b0, "r016_regrant");

    // Reset during grant of 1.
    step(4'b0011, 1'b0, 1'b0, 2'd0, 1'b0, "r027_reset");
    step(4'b0011, 1'b1, 1'b1, 2'd0, 1'b0, "r027_g0");

`ifdef ARB_TIMEOUT_EN
    step(4'b0011, 1'b1, 1'b1, 2'd0, 1'b0, "r028_h1");
    step(4'b0011, 1'b1, 1'b1, 2'd0, 1'b0, "r028_h2");
    step(4'b0011, 1'b1, 1'b1, 2'd0, 1'b0, "r028_h3");
    step(4'b0011, 1'b1, 1'b0, 2'd0, 1'b1, "r028_timeout");
    step(4'b0011, 1'b1, 1'b1, 2'd1, 1'b0, "r028_g1");
    step(4'b0010, 1'b1, 1'b1, 2'd1, 1'b0, "r028_h1b");
    step(4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, "r028_rel");
`else
    for (int i = 0; i < 300; i++) begin
      step(4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, "r029_long_hold");
    end
    step(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, "r029_rel");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
